// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and helpers for the pipeline stage register
package pipe_pkg;

  localparam int PIPE_EX_BIT     = 0;
  localparam int PIPE_SKID_DEPTH = 2;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int PIPE_CNT_W = count_w(PIPE_SKID_DEPTH);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready beat bundle between pipeline stages
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              ex;

  modport master (output valid, data, ex, input ready);
  modport slave  (input valid, data, ex, output ready);
endinterface

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one valid+payload+exception register slot
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int W          = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  input  logic         d_ex,
  output logic         valid,
  output logic [W-1:0] q,
  output logic         q_ex
);

  // Exception tag lives at the bottom of the packed slot.
  logic [W:0] store;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      store <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      if (CLEAR_DATA) store <= '0;
      else            store[PIPE_EX_BIT] <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      store <= {d, d_ex};
    end
  end

  assign q    = store[W:1];
  assign q_ex = store[PIPE_EX_BIT];

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage register with optional skid slot and exception fence
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit SKID       = 1'b0,
  parameter bit CLEAR_DATA = 1'b1,
  parameter bit EX_FENCE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_reg_if.slave       up,
  pipe_stage_reg_if.master      dn,
  output logic [PIPE_CNT_W-1:0] count,
  output logic                  fenced
);

  logic              accept, pop, s_to_m, m_load, m_clr;
  logic              m_valid, m_ex, s_valid, s_ex, m_d_ex;
  logic [DATA_W-1:0] m_data, s_data, m_d;

  assign accept = up.valid & up.ready & ~flush;
  assign pop    = m_valid & dn.ready;
  assign s_to_m = pop & s_valid;

  // With SKID=0 s_valid is tied low and these reduce to the single-entry case.
  assign m_load = s_to_m | (accept & (~m_valid | pop));
  assign m_clr  = flush | (pop & ~s_valid & ~accept);
  assign m_d    = s_to_m ? s_data : up.data;
  assign m_d_ex = s_to_m ? s_ex   : up.ex;

  pipe_entry #(.W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_m (
    .clk(clk), .rst(rst), .load(m_load), .clr(m_clr),
    .d(m_d), .d_ex(m_d_ex),
    .valid(m_valid), .q(m_data), .q_ex(m_ex)
  );

  generate
    if (SKID) begin : g_skid
      logic s_load, s_clr;
      assign s_load = accept & m_valid & ~pop;
      assign s_clr  = flush | s_to_m;

      pipe_entry #(.W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_s (
        .clk(clk), .rst(rst), .load(s_load), .clr(s_clr),
        .d(up.data), .d_ex(up.ex),
        .valid(s_valid), .q(s_data), .q_ex(s_ex)
      );

      // Built only from flops, so out_ready never reaches the upstream allowin.
      assign up.ready = ~s_valid & ~fenced;
    end else begin : g_single
      assign s_valid  = 1'b0;
      assign s_data   = '0;
      assign s_ex     = 1'b0;
      assign up.ready = ~fenced & (~m_valid | dn.ready);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)                              fenced <= 1'b0;
    else if (flush)                       fenced <= 1'b0;
    else if (EX_FENCE && accept && up.ex) fenced <= 1'b1;
  end

  assign dn.valid = m_valid;
  assign dn.data  = m_data;
  assign dn.ex    = m_ex;
  assign count    = PIPE_CNT_W'(m_valid) + PIPE_CNT_W'(s_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32)) a_up();
  pipe_stage_reg_if #(.DATA_W(32)) a_dn();
  pipe_stage_reg_if #(.DATA_W(32)) b_up();
  pipe_stage_reg_if #(.DATA_W(32)) b_dn();
  pipe_stage_reg_if #(.DATA_W(32)) c_up();
  pipe_stage_reg_if #(.DATA_W(32)) c_dn();
  logic [PIPE_CNT_W-1:0] a_cnt, b_cnt, c_cnt;
  logic a_fen, b_fen, c_fen;

  pipe_stage_reg #(.DATA_W(32), .SKID(1'b0), .CLEAR_DATA(1'b1), .EX_FENCE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .up(a_up), .dn(a_dn), .count(a_cnt), .fenced(a_fen));
  pipe_stage_reg #(.DATA_W(32), .SKID(1'b1), .CLEAR_DATA(1'b1), .EX_FENCE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .up(b_up), .dn(b_dn), .count(b_cnt), .fenced(b_fen));
  pipe_stage_reg #(.DATA_W(32), .SKID(1'b0), .CLEAR_DATA(1'b0), .EX_FENCE(1'b0)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .up(c_up), .dn(c_dn), .count(c_cnt), .fenced(c_fen));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;

    rst = 1'b1; flush = 1'b0;
    a_up.valid = 0; a_up.data = '0; a_up.ex = 0; a_dn.ready = 1;
    b_up.valid = 0; b_up.data = '0; b_up.ex = 0; b_dn.ready = 0;
    c_up.valid = 0; c_up.data = '0; c_up.ex = 0; c_dn.ready = 1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_a_valid", 32'(a_dn.valid), 0);
    chk("rst_a_data",  a_dn.data, 0);
    chk("rst_a_ex",    32'(a_dn.ex), 0);
    chk("rst_a_count", 32'(a_cnt), 0);
    chk("rst_a_fen",   32'(a_fen), 0);
    chk("rst_a_ready", 32'(a_up.ready), 1);
    chk("rst_b_ready", 32'(b_up.ready), 1);
    chk("rst_b_count", 32'(b_cnt), 0);

    // Streaming through the single-entry stage, no gaps
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        chk($sformatf("str_data%0d", i), a_dn.data, vals[i-1]);
        chk($sformatf("str_cnt%0d", i), 32'(a_cnt), 1);
        chk($sformatf("str_valid%0d", i), 32'(a_dn.valid), 1);
      end
      chk($sformatf("str_ready%0d", i), 32'(a_up.ready), 1);
      if (i < 3) begin a_up.valid = 1; a_up.data = vals[i]; end
      else a_up.valid = 0;
      cyc();
    end
    chk("str_end_valid", 32'(a_dn.valid), 0);
    chk("str_end_data",  a_dn.data, 0);
    chk("str_end_cnt",   32'(a_cnt), 0);

    // Skid stall: A to M, B to S, C held upstream
    b_up.valid = 1; b_up.data = 32'hA; cyc();
    b_up.data = 32'hB; cyc();
    b_up.data = 32'hC;
    chk("stall_cnt2",   32'(b_cnt), 2);
    chk("stall_ready0", 32'(b_up.ready), 0);
    chk("stall_dataA",  b_dn.data, 32'hA);
    cyc();
    chk("stall_hold_cnt",  32'(b_cnt), 2);
    chk("stall_hold_data", b_dn.data, 32'hA);
    b_dn.ready = 1; cyc();
    chk("drain_dataB", b_dn.data, 32'hB);
    chk("drain_cntB",  32'(b_cnt), 1);
    chk("drain_ready", 32'(b_up.ready), 1);
    cyc();
    chk("drain_dataC", b_dn.data, 32'hC);
    chk("drain_cntC",  32'(b_cnt), 1);
    b_up.valid = 0; cyc();
    chk("drain_empty", 32'(b_dn.valid), 0);

    // Flush collides with a new beat; 0x7 must never appear
    b_dn.ready = 0;
    b_up.valid = 1; b_up.data = 32'h5; cyc();
    b_up.data = 32'h6; cyc();
    chk("fl_pre_cnt", 32'(b_cnt), 2);
    b_up.data = 32'h7; flush = 1; cyc();
    flush = 0; b_up.valid = 0;
    chk("fl_valid", 32'(b_dn.valid), 0);
    chk("fl_cnt",   32'(b_cnt), 0);
    chk("fl_data",  b_dn.data, 0);
    b_dn.ready = 1; cyc();
    chk("fl_no7_valid", 32'(b_dn.valid), 0);
    chk("fl_no7_data",  b_dn.data, 0);

    // Exception fence
    b_dn.ready = 0;
    b_up.valid = 1; b_up.data = 32'h40; b_up.ex = 1; cyc();
    b_up.data = 32'h41; b_up.ex = 0;
    chk("fen_set",    32'(b_fen), 1);
    chk("fen_ready0", 32'(b_up.ready), 0);
    chk("fen_data40", b_dn.data, 32'h40);
    chk("fen_ex",     32'(b_dn.ex), 1);
    cyc();
    chk("fen_blocked", 32'(b_cnt), 1);
    b_dn.ready = 1; cyc();
    chk("fen_drained", 32'(b_dn.valid), 0);
    chk("fen_ex_idle", 32'(b_dn.ex), 0);
    chk("fen_still",   32'(b_fen), 1);
    flush = 1; cyc();
    flush = 0;
    chk("fen_clear", 32'(b_fen), 0);
    chk("fen_ready", 32'(b_up.ready), 1);
    cyc();
    b_up.valid = 0;
    chk("fen_acc41_valid", 32'(b_dn.valid), 1);
    chk("fen_acc41_data",  b_dn.data, 32'h41);
    chk("fen_acc41_ex",    32'(b_dn.ex), 0);
    cyc();

    // Reset with both entries full and the fence raised
    b_dn.ready = 0;
    b_up.valid = 1; b_up.data = 32'h1; b_up.ex = 0; cyc();
    b_up.data = 32'h2; b_up.ex = 1; cyc();
    b_up.valid = 0; b_up.ex = 0;
    chk("mr_cnt2", 32'(b_cnt), 2);
    chk("mr_fen",  32'(b_fen), 1);
    rst = 1; cyc();
    rst = 0;
    chk("mr_valid", 32'(b_dn.valid), 0);
    chk("mr_cnt",   32'(b_cnt), 0);
    chk("mr_fen0",  32'(b_fen), 0);
    chk("mr_ready", 32'(b_up.ready), 1);

    // CLEAR_DATA=0: data survives pop-to-empty, ex tag does not
    c_up.valid = 1; c_up.data = 32'hDEAD; c_up.ex = 1; cyc();
    c_up.valid = 0; c_up.ex = 0;
    chk("cd_valid", 32'(c_dn.valid), 1);
    chk("cd_data",  c_dn.data, 32'hDEAD);
    chk("cd_nofen", 32'(c_fen), 0);
    cyc();
    chk("cd_pop_valid", 32'(c_dn.valid), 0);
    chk("cd_pop_data",  c_dn.data, 32'hDEAD);
    chk("cd_pop_ex",    32'(c_dn.ex), 0);
    chk("cd_pop_cnt",   32'(c_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage register for the in-order pipeline. It replaces the hand-written per-stage register blocks such as the MEM->WB register.
- Payload width is set by a parameter; all per-instruction fields are concatenated into one vector.
- Uses a valid/ready (allowin) handshake and holds its contents on stall. Older per-stage blocks inserted bubbles instead.
- Optional 2-entry skid buffer registers the upstream ready path.
- Supports pipeline flush and an exception-fence mode.

Parameters:
DATA_W, 32, payload width in bits (1..512).
SKID, 0, 0 = single entry, in_ready combinational from out_ready; 1 = 2-entry skid buffer, in_ready is a flop output.
CLEAR_DATA, 1, 1 = data registers zeroed on reset, flush and pop-to-empty; 0 = data registers hold their value and only the valid bits clear.
EX_FENCE, 1, 1 = after an exception-tagged beat is accepted, no further beats are accepted until flush.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  kill all contents (exception/ertn commit from WB)
in_valid  in  1  upstream beat valid
in_ready  out  1  stage allowin
in_data  in  DATA_W  upstream payload
in_ex  in  1  beat carries an exception
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream allowin
out_data  out  DATA_W  payload of oldest entry
out_ex  out  1  exception tag of oldest entry
count  out  2  occupancy, 0..1 if SKID=0, 0..2 if SKID=1
fenced  out  1  exception fence active

Behaviour:
- Reset: out_valid=0, out_ex=0, out_data=0, count=0, fenced=0.
  - in_ready=1 if SKID=1; if SKID=0, in_ready follows the combinational formula below.
- Handshake events:
  - accept = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
  - A beat is transferred only on the clock edge where its handshake is high.
- Storage:
  - Main entry M drives the outputs.
  - Skid entry S exists only when SKID=1.
  - Entries are strictly FIFO ordered.
- SKID=0:
  - in_ready = ~fenced & (~m_valid | out_ready).
  - accept loads M. pop without accept leaves M empty.
  - Latency is 1 cycle, throughput 1 beat per cycle.
- SKID=1:
  - in_ready = ~s_valid & ~fenced, with no combinational path from out_ready.
  - accept while M empty, or while M pops with S empty: beat goes to M.
  - accept while M full and not popping: beat goes to S.
  - pop with S valid: S moves to M. A simultaneous accept is impossible because in_ready=0.
- Flush:
  - All valid bits clear on the next edge and fenced clears.
  - A beat presented in the flush cycle is dropped.
  - A pop in the flush cycle still completes, because downstream sampled it.
  - Flush has priority over accept; rst has priority over flush.
- EX_FENCE=1:
  - fenced sets on the edge where a beat with in_ex=1 is accepted.
  - While fenced, in_ready=0; the fenced beat and older beats still drain.
  - fenced clears only on flush or rst.
- EX_FENCE=0: fenced stays 0.
- CLEAR_DATA=1: out_data=0 and out_ex=0 whenever out_valid=0.
- out_ex is 0 whenever out_valid=0, regardless of CLEAR_DATA.
- count = m_valid + s_valid. count never exceeds 1 (SKID=0) or 2 (SKID=1).
- No X-propagation: in_* are ignored while in_valid=0.

Decomposition:
- Shared package pipe_pkg:
  - localparams PIPE_EX_BIT and PIPE_SKID_DEPTH=2.
  - Function for count width.
- One natural sub-module: pipe_entry, a single valid+data+ex register with load, clear and CLEAR_DATA handling.
  - Instantiated once for M and once for S (S under generate SKID=1).
- Top-level holds the handshake and fence logic.

Test Plan:
- Streaming, SKID=0, DATA_W=32, out_ready=1:
  - Drive 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later, count=1 steady, no gaps.
- Stall, SKID=1:
  - Deassert out_ready while sending 0xA,0xB,0xC -> 0xA held in M, 0xB in S, in_ready=0 with count=2, 0xC held upstream.
  - Release out_ready -> outputs 0xA,0xB,0xC in order.
- Flush collision:
  - M holds 0x5, S holds 0x6; assert flush with in_valid=1, in_data=0x7 -> next cycle out_valid=0, count=0, out_data=0 (CLEAR_DATA=1).
  - 0x7 is never output.
- Exception fence, EX_FENCE=1:
  - Accept 0x40 with in_ex=1, then offer 0x41 -> fenced=1, in_ready=0, 0x40 output with out_ex=1, 0x41 not accepted.
  - Pulse flush -> fenced=0 and 0x41 is accepted next cycle.
- Reset mid-operation, SKID=1:
  - count=2, assert rst for 1 cycle -> out_valid=0, count=0, fenced=0, in_ready=1 on the following cycle.
- CLEAR_DATA=0:
  - Pop last entry 0xDEAD -> out_valid=0, out_data remains 0xDEAD, out_ex=0.
